dmem_responder: RTL and testbench

Memory-side responder for the CPU data port. The CPU drives memaddr, memwrite and memwritedata. This block serves the access after a programmable number of wait states, using a stall/ready handshake. It contains a word-organised data RAM with byte-lane writes, which carries sb/sh alongside the existing lbu path. It also decodes a small MMIO window: an LED register and a free-running cycle counter.

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_responder_if.sv | 22 ++
 rtl/dmem_responder_mmio_regs.sv | 54 +++++
 rtl/dmem_responder.sv | 140 ++++++++++++++
 tb/tb_dmem_responder.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the CPU data-port memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_e;

  localparam logic [3:0] REGION_RAM  = 4'h0;
  localparam logic [3:0] REGION_MMIO = 4'hF;

  localparam logic [1:0] OFF_LED  = 2'd0;
  localparam logic [1:0] OFF_CNT  = 2'd1;
  localparam logic [1:0] OFF_STAT = 2'd2;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  // Access captured in IDLE and replayed while waiting.
  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// CPU data-port bus: request fields from the CPU, completion fields back.
interface dmem_responder_if;
  logic        req;
  logic        memwrite;
  logic [3:0]  byteen;
  logic [31:0] memaddr;
  logic [31:0] memwritedata;
  logic [31:0] memreaddata;
  logic        ready;
  logic        stall;
  logic        err;

  modport master (
    output req, memwrite, byteen, memaddr, memwritedata,
    input  memreaddata, ready, stall, err
  );

  modport slave (
    input  req, memwrite, byteen, memaddr, memwritedata,
    output memreaddata, ready, stall, err
  );
endinterface

// File: rtl/dmem_responder_mmio_regs.sv
// MMIO register file: LED register, free-running cycle counter, status word.
module mmio_regs
  import dmem_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [1:0]        offset,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   byteen,
  output logic [DATA_W-1:0] rdata,
  output logic [7:0]        led
);

  logic [7:0]        led_q, led_d;
  logic [DATA_W-1:0] cyc_q, cyc_d;

  always_comb begin
    led_d = led_q;
    cyc_d = cyc_q + DATA_W'(1);
    if (we && offset == OFF_LED && byteen[0]) begin
      led_d = wdata[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q <= '0;
      cyc_q <= '0;
    end else begin
      led_q <= led_d;
      cyc_q <= cyc_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (offset)
      OFF_LED:  rdata = {24'b0, led_q};
      OFF_CNT:  rdata = cyc_q;
      OFF_STAT: rdata = {28'b0, 4'(WAIT_STATES)};
      default:  rdata = '0;
    endcase
  end

  assign led = led_q;

  // Only the low LED byte and its lane enable matter here.
  logic unused_wbits;
  assign unused_wbits = ^{wdata[31:8], byteen[3:1]};

endmodule

// File: rtl/dmem_responder.sv
// Data-port responder: wait-state FSM, byte-lane RAM and MMIO window decode.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus,
  output logic [7:0]        led
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  dmem_req_t         lat_q, lat_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  dmem_req_t         cur;
  logic              is_ram, is_mmio, unmapped;
  logic              commit;
  logic              ram_we, mmio_we;
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic [DATA_W-1:0] ram_rdata, mmio_rdata;
  logic [DATA_W-1:0] mem [DEPTH];

  // In IDLE the live bus is the access; afterwards the latched copy is.
  always_comb begin
    cur = lat_q;
    if (state_q == ST_IDLE) begin
      cur.we    = bus.memwrite;
      cur.be    = bus.byteen;
      cur.addr  = bus.memaddr;
      cur.wdata = bus.memwritedata;
    end
  end

  always_comb begin
    is_ram   = (cur.addr[31:28] == REGION_RAM) && (cur.addr[27:DEPTH_LOG2+2] == '0);
    is_mmio  = (cur.addr[31:28] == REGION_MMIO) && (cur.addr[3:2] != 2'd3);
    unmapped = !(is_ram || is_mmio);
    ram_idx  = cur.addr[DEPTH_LOG2+1:2];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          lat_d = cur;
          if (WAIT_STATES == 0) begin
            state_d = ST_DONE;
            commit  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Read data and error are captured on the edge entering DONE.
    if (commit) begin
      err_d = unmapped;
      if (unmapped)    rdata_d = '0;
      else if (is_ram) rdata_d = ram_rdata;
      else             rdata_d = mmio_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lat_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign ram_we  = commit && is_ram && cur.we && !reset;
  assign mmio_we = commit && is_mmio && cur.we && !reset;

  // RAM has no reset; a read in the commit cycle sees pre-write contents.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (cur.be[i]) mem[ram_idx][8*i +: 8] <= cur.wdata[8*i +: 8];
      end
    end
  end

  assign ram_rdata = mem[ram_idx];

  mmio_regs #(
    .WAIT_STATES(WAIT_STATES)
  ) u_mmio (
    .clk    (clk),
    .reset  (reset),
    .we     (mmio_we),
    .offset (cur.addr[3:2]),
    .wdata  (cur.wdata),
    .byteen (cur.be),
    .rdata  (mmio_rdata),
    .led    (led)
  );

  assign bus.stall       = !reset && (((state_q == ST_IDLE) && bus.req) || (state_q == ST_WAIT));
  assign bus.ready       = (state_q == ST_DONE);
  assign bus.err         = err_q;
  assign bus.memreaddata = rdata_q;

  // The CPU selects bytes within the word itself.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cur.addr[1:0];

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with two wait states, one with none.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int unsigned WS0 = 2;
  localparam int unsigned WS1 = 0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] led0, led1;

  dmem_responder_if bus0 ();
  dmem_responder_if bus1 ();

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(WS0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .led(led0));
  dmem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(WS1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .led(led1));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        chk;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;

  // Reference cycle counter: clears with reset, counts every edge otherwise.
  logic [31:0] tb_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) tb_cnt <= '0;
    else       tb_cnt <= tb_cnt + 32'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus0.ready === 1'b1) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ready0: got ready with empty queue at %0t", $time);
      end else begin
        e = q0.pop_front();
        check("err0", 32'(bus0.err), 32'(e.err));
        if (e.chk) check("rdata0", bus0.memreaddata, e.data);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus1.ready === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ready1: got ready with empty queue at %0t", $time);
      end else begin
        e = q1.pop_front();
        check("err1", 32'(bus1.err), 32'(e.err));
        if (e.chk) check("rdata1", bus1.memreaddata, e.data);
      end
    end
  end

  task automatic acc0(input logic we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wd, input logic chk, input logic [31:0] exp_d,
                      input logic exp_err, input logic cnt_mode);
    int   n;
    int   st;
    exp_t e;
    @(negedge clk);
    bus0.req = 1'b1; bus0.memwrite = we; bus0.byteen = be;
    bus0.memaddr = addr; bus0.memwritedata = wd;
    e.data = cnt_mode ? tb_cnt + 32'(WS0) : exp_d;
    e.err  = exp_err;
    e.chk  = chk;
    q0.push_back(e);
    n = 0; st = 0;
    #1;
    while (bus0.ready !== 1'b1 && n < 20) begin
      if (bus0.stall === 1'b1) st++;
      @(negedge clk); #1;
      n++;
    end
    check("latency0", n, WS0 + 1);
    check("stall_cycles0", st, WS0 + 1);
    check("stall_in_done0", 32'(bus0.stall), 32'd0);
    bus0.req = 1'b0;
  endtask

  task automatic acc1(input logic we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wd, input logic chk, input logic [31:0] exp_d);
    exp_t e;
    @(negedge clk);
    bus1.req = 1'b1; bus1.memwrite = we; bus1.byteen = be;
    bus1.memaddr = addr; bus1.memwritedata = wd;
    e.data = exp_d; e.err = 1'b0; e.chk = chk;
    q1.push_back(e);
    #1;
    check("stall_req1", 32'(bus1.stall), 32'd1);
    @(negedge clk); #1;
    check("ready_lat1", 32'(bus1.ready), 32'd1);
    check("stall_done1", 32'(bus1.stall), 32'd0);
    bus1.req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bus0.req = 1'b0; bus0.memwrite = 1'b0; bus0.byteen = '0;
    bus0.memaddr = '0; bus0.memwritedata = '0;
    bus1.req = 1'b0; bus1.memwrite = 1'b0; bus1.byteen = '0;
    bus1.memaddr = '0; bus1.memwritedata = '0;

    // Reset state, including stall held low while reset is high.
    repeat (2) @(negedge clk);
    bus0.req = 1'b1; #1;
    check("stall_in_reset", 32'(bus0.stall), 32'd0);
    bus0.req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_led", 32'(led0), 32'd0);
    check("rst_ready", 32'(bus0.ready), 32'd0);
    check("rst_err", 32'(bus0.err), 32'd0);
    check("rst_rdata", bus0.memreaddata, 32'd0);
    check("rst_stall_noreq", 32'(bus0.stall), 32'd0);

    // Full-word write then read back.
    acc0(1'b1, 4'b1111, 32'h40, 32'h12345678, 1'b0, 32'h0, 1'b0, 1'b0);
    acc0(1'b0, 4'b0000, 32'h40, 32'h0, 1'b1, 32'h12345678, 1'b0, 1'b0);

    // Byte-lane writes; byteen=0 leaves the word alone; addr[1:0] ignored.
    acc0(1'b1, 4'b0010, 32'h40, 32'h0000AB00, 1'b0, 32'h0, 1'b0, 1'b0);
    acc0(1'b0, 4'b0000, 32'h40, 32'h0, 1'b1, 32'h1234AB78, 1'b0, 1'b0);
    acc0(1'b1, 4'b0000, 32'h40, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0, 1'b0);
    acc0(1'b0, 4'b0000, 32'h40, 32'h0, 1'b1, 32'h1234AB78, 1'b0, 1'b0);
    acc0(1'b1, 4'b1000, 32'h43, 32'hEE000000, 1'b0, 32'h0, 1'b0, 1'b0);
    acc0(1'b0, 4'b0000, 32'h41, 32'h0, 1'b1, 32'hEE34AB78, 1'b0, 1'b0);

    // MMIO: LED, counter (read twice, write ignored), status, hole at offset 3.
    acc0(1'b1, 4'b0001, 32'hF0000000, 32'h000001A5, 1'b0, 32'h0, 1'b0, 1'b0);
    check("led_after_write", 32'(led0), 32'hA5);
    acc0(1'b0, 4'b0000, 32'hF0000000, 32'h0, 1'b1, 32'h000000A5, 1'b0, 1'b0);
    acc0(1'b0, 4'b0000, 32'hF0000004, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    acc0(1'b0, 4'b0000, 32'hF0000004, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
    acc0(1'b0, 4'b0000, 32'hF0000008, 32'h0, 1'b1, 32'h00000002, 1'b0, 1'b0);
    acc0(1'b1, 4'b1111, 32'hF0000004, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    acc0(1'b0, 4'b0000, 32'hF0000004, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
    acc0(1'b0, 4'b0000, 32'hF000000C, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);

    // Unmapped region and out-of-range RAM address.
    acc0(1'b1, 4'b1111, 32'h0, 32'h11223344, 1'b0, 32'h0, 1'b0, 1'b0);
    acc0(1'b0, 4'b0000, 32'h20000000, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
    acc0(1'b1, 4'b1111, 32'h00100000, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b1, 1'b0);
    acc0(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 32'h11223344, 1'b0, 1'b0);

    // Reset in the middle of a write's wait states.
    acc0(1'b1, 4'b1111, 32'h80, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    bus0.req = 1'b1; bus0.memwrite = 1'b1; bus0.byteen = 4'b1111;
    bus0.memaddr = 32'h80; bus0.memwritedata = 32'hDEADBEEF;
    @(negedge clk); #1;
    check("stall_in_wait", 32'(bus0.stall), 32'd1);
    reset = 1'b1; #1;
    check("stall_mid_reset", 32'(bus0.stall), 32'd0);
    check("led_mid_reset", 32'(led0), 32'd0);
    repeat (2) begin
      @(negedge clk); #1;
      check("no_ready_in_reset", 32'(bus0.ready), 32'd0);
    end
    bus0.req = 1'b0;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      check("no_ready_after_reset", 32'(bus0.ready), 32'd0);
    end
    check("led_after_reset", 32'(led0), 32'd0);
    acc0(1'b0, 4'b0000, 32'h80, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0);
    acc0(1'b0, 4'b0000, 32'hF0000004, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);

    // Zero wait states: single access, then back-to-back reads.
    acc1(1'b1, 4'b1111, 32'h40, 32'h5A5A1234, 1'b0, 32'h0);
    acc1(1'b0, 4'b0000, 32'h40, 32'h0, 1'b1, 32'h5A5A1234);
    @(negedge clk);
    bus1.req = 1'b1; bus1.memwrite = 1'b0; bus1.byteen = '0; bus1.memaddr = 32'h40;
    e.data = 32'h5A5A1234; e.err = 1'b0; e.chk = 1'b1;
    q1.push_back(e);
    #1;
    check("b2b_stall_c0", 32'(bus1.stall), 32'd1);
    @(negedge clk); #1;
    check("b2b_ready_c1", 32'(bus1.ready), 32'd1);
    q1.push_back(e);
    @(negedge clk); #1;
    check("b2b_ready_c2", 32'(bus1.ready), 32'd0);
    check("b2b_stall_c2", 32'(bus1.stall), 32'd1);
    @(negedge clk); #1;
    check("b2b_ready_c3", 32'(bus1.ready), 32'd1);
    bus1.req = 1'b0;

    repeat (3) @(negedge clk);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
